// File: rtl/hood_pkg.sv
// Shared hood-panel definitions: hold-state encoding and default timing constants
// (100 MHz clock), also used by the mode controller.
package hood_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HELD      = 2'd1,
    LONG_HELD = 2'd2
  } hold_state_e;

  localparam int unsigned DEF_DEBOUNCE_CYCLES   = 2_000_000;
  localparam int unsigned DEF_LONG_PRESS_CYCLES = 300_000_000;
  localparam int unsigned DEF_REPEAT_CYCLES     = 20_000_000;

  // Width needed to hold 0..max_val, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/button_conditioner_btn_channel.sv
// One button channel: 2-flop synchroniser, debounce counter and hold FSM.
// Auto-repeat logic is present only when BTN_AUTOREPEAT_EN is defined.
module btn_channel
  import hood_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
  parameter int unsigned REPEAT_CYCLES     = DEF_REPEAT_CYCLES
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o,
  output logic repeat_o
);

  localparam int unsigned DW = cnt_width(DEBOUNCE_CYCLES - 1);
  localparam int unsigned HW = cnt_width(LONG_PRESS_CYCLES - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);

  logic          s1_q, s2_q;
  logic          level_q, level_d;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic          toggle;
  hold_state_e   state_q, state_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          long_q, long_d;

  // Any cycle where the synchronised input agrees with the level restarts the count.
  always_comb begin
    level_d  = level_q;
    db_cnt_d = '0;
    toggle   = 1'b0;
    if (s2_q != level_q) begin
      if (db_cnt_q == DB_LAST) begin
        toggle  = 1'b1;
        level_d = ~level_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    long_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (toggle && !level_q) begin
          state_d    = HELD;
          press_d    = 1'b1;
          hold_cnt_d = '0;
        end
      end
      HELD: begin
        // A fall takes precedence over the long-press threshold.
        if (toggle) begin
          state_d    = IDLE;
          release_d  = 1'b1;
          hold_cnt_d = '0;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d    = LONG_HELD;
          long_d     = 1'b1;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      LONG_HELD: begin
        if (toggle) begin
          state_d   = IDLE;
          release_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      level_q    <= 1'b0;
      db_cnt_q   <= '0;
      state_q    <= IDLE;
      hold_cnt_q <= '0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      long_q     <= 1'b0;
    end else begin
      s1_q       <= raw_i;
      s2_q       <= s1_q;
      level_q    <= level_d;
      db_cnt_q   <= db_cnt_d;
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      press_q    <= press_d;
      release_q  <= release_d;
      long_q     <= long_d;
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int unsigned RW = cnt_width(REPEAT_CYCLES - 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
  logic          repeat_q, repeat_d;

  // Counter sits at zero outside LONG_HELD, so it starts fresh on every long press.
  always_comb begin
    rep_cnt_d = '0;
    repeat_d  = 1'b0;
    if (state_q == LONG_HELD && !toggle) begin
      if (rep_cnt_q == REP_LAST) begin
        repeat_d = 1'b1;
      end else begin
        rep_cnt_d = rep_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rep_cnt_q <= '0;
      repeat_q  <= 1'b0;
    end else begin
      rep_cnt_q <= rep_cnt_d;
      repeat_q  <= repeat_d;
    end
  end

  assign repeat_o = repeat_q;
`else
  assign repeat_o = 1'b0;
`endif

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;

endmodule

// File: rtl/button_conditioner.sv
// Hood-panel button front end: N_BTN independent btn_channel instances.
// Define BTN_AUTOREPEAT_EN to build the auto-repeat outputs.
module button_conditioner
  import hood_pkg::*;
#(
  parameter int unsigned N_BTN             = 7,
  parameter int unsigned DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
  parameter int unsigned REPEAT_CYCLES     = DEF_REPEAT_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_long,
  output logic [N_BTN-1:0] btn_repeat
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
      .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES),
      .REPEAT_CYCLES    (REPEAT_CYCLES)
    ) u_ch (
      .clk_i    (clk),
      .reset_i  (reset),
      .raw_i    (btn_raw[i]),
      .level_o  (btn_level[i]),
      .press_o  (btn_press[i]),
      .release_o(btn_release[i]),
      .long_o   (btn_long[i]),
      .repeat_o (btn_repeat[i])
    );
  end

endmodule
